e_mdu: RTL and testbench
========================

# e_mdu

Parametrised multiply/divide unit in the EX stage, alongside the ALU. Executes signed/unsigned multiply, multiply-accumulate and divide over a fixed multi-cycle latency, and holds the results in the architectural HI/LO registers. Asserts `busy` so the hazard unit can stall dependent HI/LO reads and new MDU instructions.

## Interface
- `WIDTH`, 32, operand and HI/LO width
- `MULT_LAT`, 5, cycles from accepted multiply/MADD to HI/LO update (≥1)
- `DIV_LAT`, 10, cycles from accepted divide to HI/LO update (≥1)
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: op request, sampled on the rising edge.
- `MDUOp` in 4: operation code.
- `SrcA` in WIDTH: rs operand, or dividend.
- `SrcB` in WIDTH: rt operand, or divisor.
- `busy` out 1: an operation is in flight.
- `HI` out WIDTH: HI register.
- `LO` out WIDTH: LO register.

## Operation
- Ops:
  - MULT / MULTU: {HI,LO} = A×B, signed / unsigned, full 2·WIDTH product.
  - MADD / MADDU: {HI,LO} += A×B, signed / unsigned, modulo 2^(2·WIDTH).
  - DIV / DIVU: LO = quotient, HI = remainder.
  - MTHI: HI = A.
  - MTLO: LO = A.
  - NOP and undefined codes: no effect.
- Accept rule: `start` is accepted only when `busy`=0. While `busy`=1, `start` is ignored entirely, including MTHI/MTLO; the stall unit must hold these back.
- State machine:
  - IDLE: accepted multi-cycle op moves to RUN. Operands and op are latched, the result is precomputed into a pending register, and the counter is loaded with the op's latency.
  - RUN: the counter decrements each cycle. At count 1, pending is committed to HI/LO and the state returns to IDLE.
- MTHI/MTLO: a single-edge write at the accepting edge. `busy` is not raised.
- Signed divide: quotient truncates toward zero; remainder takes the sign of the dividend.
  - MIN / −1: LO = MIN, HI = 0.
- Divide by zero, signed or unsigned: the op occupies DIV_LAT cycles, then HI/LO are left unchanged.
- MADD/MADDU accumulate onto the HI/LO value present at the accepting edge.
- HI/LO outputs always show committed values. They are never intermediate.
- Reset (async, mid-operation included): state IDLE, counter 0, `busy`=0, HI=0, LO=0. The pending result is discarded.

## Timing
- Op accepted at edge E0:
  - `busy`=1 from after E0 through the cycle before E_LAT.
  - HI/LO change and `busy` falls at edge E_LAT = E0+LAT.
  - `busy` is high for exactly LAT cycles.
- The cycle in which `start` is high is not itself covered by `busy`. The hazard unit stalls on `start|busy`.
- Back-to-back: a new `start` in the cycle `busy` reads 0 after completion is accepted at the next edge. There is no dead cycle.
- MTHI/MTLO accepted at E0: the new value is visible after E0. The other register is unchanged.
- Outputs are registered. There is no combinational path from inputs to HI/LO/busy.

## Structure
- Shared package `mdu_pkg` holds the MDUOp encodings and the op-class helper (mult / madd / div / move).
  - The same encodings are used by the controller.
- Sub-module `mdu_div`: combinational signed/unsigned divider with the MIN/−1 and divide-by-zero flags.
- Multiply and the FSM stay in `e_mdu`.

## Test plan
- Reset mid-operation: MULT 7×6, assert `rst_n`=0 at cycle 2 → `busy`=0 and HI=LO=0 immediately; no later update.
- MULT 0xFFFFFFFF×2 → HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands → HI=1, LO=0xFFFFFFFE. In both cases `busy` is high for exactly 5 cycles.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1; `busy` is high for 10 cycles.
- DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0. DIVU 5/0 after MTHI 0xAA → HI=0xAA and LO unchanged.
- Contention: MTLO 0x1234 presented with `start` while `busy` → ignored; LO equals the MULT result. MTLO issued after completion → LO=0x1234.
- MADD with HI=0, LO=0xFFFFFFFF, operands 1×1 → HI=1, LO=0. Back-to-back MULT accepted on the edge after `busy` falls completes 5 cycles later.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared MDU opcode encodings and the op-class decode used by the MDU and the controller.
package mdu_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_MULT  = 4'h1;
  localparam logic [3:0] OP_MULTU = 4'h2;
  localparam logic [3:0] OP_MADD  = 4'h3;
  localparam logic [3:0] OP_MADDU = 4'h4;
  localparam logic [3:0] OP_DIV   = 4'h5;
  localparam logic [3:0] OP_DIVU  = 4'h6;
  localparam logic [3:0] OP_MTHI  = 4'h7;
  localparam logic [3:0] OP_MTLO  = 4'h8;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_MULT,
    CLS_MADD,
    CLS_DIV,
    CLS_MOVE
  } op_class_e;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } mdu_state_e;

  function automatic op_class_e op_class(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU: return CLS_MULT;
      OP_MADD, OP_MADDU: return CLS_MADD;
      OP_DIV,  OP_DIVU:  return CLS_DIV;
      OP_MTHI, OP_MTLO:  return CLS_MOVE;
      default:           return CLS_NONE;
    endcase
  endfunction

  function automatic logic op_signed(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_div.sv
// Combinational signed/unsigned divider; flags divide-by-zero and the MIN/-1 overflow case.
module mdu_div #(
  parameter int WIDTH = 32
) (
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_r,
  output logic             o_dz,
  output logic             o_ovf
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_den;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;

  // Divide magnitudes, then restore signs: quotient truncates toward zero, remainder follows dividend.
  assign w_neg_a = i_signed & i_a[WIDTH-1];
  assign w_neg_b = i_signed & i_b[WIDTH-1];
  assign w_mag_a = w_neg_a ? -i_a : i_a;
  assign w_mag_b = w_neg_b ? -i_b : i_b;

  assign o_dz  = (i_b == '0);
  assign o_ovf = i_signed && (i_a == MIN_VAL) && (i_b == '1);

  // Substitute a harmless divisor on zero so the result is defined; the caller discards it.
  assign w_den = o_dz ? WIDTH'(1) : w_mag_b;
  assign w_q   = w_mag_a / w_den;
  assign w_r   = w_mag_a % w_den;

  assign o_q = o_ovf ? MIN_VAL : ((w_neg_a ^ w_neg_b) ? -w_q : w_q);
  assign o_r = o_ovf ? '0      : (w_neg_a ? -w_r : w_r);

endmodule

// File: rtl/e_mdu.sv
// EX-stage multiply/divide unit: fixed-latency MULT/MADD/DIV into HI/LO, single-edge MTHI/MTLO.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       MDUOp,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MULT_LAT_C = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_LAT_C  = CNT_W'(DIV_LAT);

  mdu_state_e         r_state;
  mdu_state_e         w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_commit;
  logic               w_accept;
  logic               w_multi;
  logic               w_sgn;
  op_class_e          w_cls;

  logic [2*WIDTH-1:0] w_ext_a;
  logic [2*WIDTH-1:0] w_ext_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;
  logic               w_dz;
  logic               w_ovf;
  logic [2*WIDTH-1:0] w_pend;
  logic [2*WIDTH-1:0] r_pend;
  logic               r_pend_wr;

  assign w_cls    = op_class(MDUOp);
  assign w_sgn    = op_signed(MDUOp);
  assign w_accept = start && (r_state == ST_IDLE);
  assign w_multi  = (w_cls == CLS_MULT) || (w_cls == CLS_MADD) || (w_cls == CLS_DIV);
  assign busy     = (r_state == ST_RUN);

  // One 2W-bit multiplier serves both signednesses: sign- or zero-extend, keep the low 2W bits.
  assign w_ext_a = {{WIDTH{w_sgn & SrcA[WIDTH-1]}}, SrcA};
  assign w_ext_b = {{WIDTH{w_sgn & SrcB[WIDTH-1]}}, SrcB};
  assign w_prod  = w_ext_a * w_ext_b;

  mdu_div #(.WIDTH(WIDTH)) u_div (
    .i_signed (w_sgn),
    .i_a      (SrcA),
    .i_b      (SrcB),
    .o_q      (w_q),
    .o_r      (w_r),
    .o_dz     (w_dz),
    .o_ovf    (w_ovf)
  );

  always_comb begin
    w_pend = w_prod;
    case (w_cls)
      CLS_MADD: w_pend = {HI, LO} + w_prod;
      CLS_DIV:  w_pend = {w_r, w_q};
      default:  w_pend = w_prod;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_multi) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = (w_cls == CLS_DIV) ? DIV_LAT_C : MULT_LAT_C;
        end
      end
      ST_RUN: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_commit    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Pending result is only consumed from RUN, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_accept && w_multi) begin
      r_pend    <= w_pend;
      r_pend_wr <= !((w_cls == CLS_DIV) && w_dz);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_commit && r_pend_wr) begin
        HI <= r_pend[2*WIDTH-1:WIDTH];
        LO <= r_pend[WIDTH-1:0];
      end else if (w_accept && (MDUOp == OP_MTHI)) begin
        HI <= SrcA;
      end else if (w_accept && (MDUOp == OP_MTLO)) begin
        LO <= SrcA;
      end
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: per-cycle compare against a behavioural HI/LO model, plus literal anchors.
module tb_e_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'h0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  e_mdu #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .MDUOp (op),
    .SrcA  (a),
    .SrcB  (b),
    .busy  (busy),
    .HI    (hi),
    .LO    (lo)
  );

  // Behavioural model: remaining busy cycles, committed HI/LO, pending 64-bit result.
  int          m_rem;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] m_pend;
  logic        m_wr;

  function automatic void model_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                   input logic [63:0] acc, output int lat,
                                   output logic [63:0] res, output logic wr);
    longint sx, sy, sq, sr;
    logic [63:0] pu;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    pu = {32'h0, x} * {32'h0, y};
    lat = 0; res = '0; wr = 1'b0;
    case (o)
      OP_MULT:  begin lat = 5; wr = 1'b1; res = 64'(sx * sy); end
      OP_MULTU: begin lat = 5; wr = 1'b1; res = pu; end
      OP_MADD:  begin lat = 5; wr = 1'b1; res = acc + 64'(sx * sy); end
      OP_MADDU: begin lat = 5; wr = 1'b1; res = acc + pu; end
      OP_DIV: begin
        lat = 10; wr = (y != 0);
        if (y != 0) begin
          sq = sx / sy; sr = sx % sy;
          res = {sr[31:0], sq[31:0]};
        end
      end
      OP_DIVU: begin
        lat = 10; wr = (y != 0);
        if (y != 0) res = {x % y, x / y};
      end
      default: lat = 0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int          lat;
    logic [63:0] res;
    logic        wr;
    if (!rst_n) begin
      m_rem <= 0; m_hi <= '0; m_lo <= '0;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1 && m_wr) begin m_hi <= m_pend[63:32]; m_lo <= m_pend[31:0]; end
    end else if (start) begin
      model_op(op, a, b, {m_hi, m_lo}, lat, res, wr);
      if (op == OP_MTHI) m_hi <= a;
      else if (op == OP_MTLO) m_lo <= a;
      else if (lat > 0) begin m_rem <= lat; m_pend <= res; m_wr <= wr; end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (busy !== (m_rem > 0) || hi !== m_hi || lo !== m_lo) begin
        errors++;
        $display("FAIL cycle t=%0t: busy=%0b HI=%h LO=%h, required busy=%0b HI=%h LO=%h",
                 $time, busy, hi, lo, (m_rem > 0), m_hi, m_lo);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the first negedge where busy reads 0.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, output int n);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("busy_timeout", 32'(n), 32'd0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy === 1'b1 && k < 50) begin
      k++;
      @(negedge clk);
    end
    if (k >= 50) chk("idle_timeout", 32'(k), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, n);
    chk("mult_busy_cycles", 32'(n), 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, n);
    chk("multu_busy_cycles", 32'(n), 32'd5);
    chk("multu_hi", hi, 32'h1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, n);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    run_op(OP_DIVU, 32'd7, 32'd2, n);
    chk("divu_busy_cycles", 32'(n), 32'd10);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'h0);

    run_op(OP_MTLO, 32'h55, 32'h0, n);
    chk("mtlo_no_busy", 32'(n), 32'd0);
    run_op(OP_MTHI, 32'hAA, 32'h0, n);
    chk("mthi_hi", hi, 32'hAA);
    chk("mthi_lo_kept", lo, 32'h55);
    run_op(OP_DIVU, 32'd5, 32'd0, n);
    chk("divz_busy_cycles", 32'(n), 32'd10);
    chk("divz_hi", hi, 32'hAA);
    chk("divz_lo", lo, 32'h55);

    // MTLO presented while busy must be dropped.
    start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd4;
    @(negedge clk);
    op = OP_MTLO; a = 32'h1234;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk("contend_lo", lo, 32'd12);
    chk("contend_hi", hi, 32'd0);
    run_op(OP_MTLO, 32'h1234, 32'h0, n);
    chk("mtlo_after_lo", lo, 32'h1234);

    run_op(OP_MTHI, 32'h0, 32'h0, n);
    run_op(OP_MTLO, 32'hFFFF_FFFF, 32'h0, n);
    run_op(OP_MADD, 32'd1, 32'd1, n);
    chk("madd_hi", hi, 32'd1);
    chk("madd_lo", lo, 32'd0);

    run_op(OP_MULT, 32'd3, 32'd5, n);
    run_op(OP_MULT, 32'd6, 32'd7, n);
    chk("b2b_busy_cycles", 32'(n), 32'd5);
    chk("b2b_lo", lo, 32'd42);

    // Asynchronous reset in the middle of a multiply.
    run_op(OP_MTHI, 32'h99, 32'h0, n);
    start = 1'b1; op = OP_MULT; a = 32'd7; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("postrst_hi", hi, 32'h0);
    chk("postrst_lo", lo, 32'h0);
    chk("postrst_busy", 32'(busy), 32'd0);

    repeat (600) begin
      start = ($urandom_range(0, 2) != 0);
      op = 4'($urandom_range(0, 15));
      a = pick();
      b = pick();
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
